// File: rtl/cache_bus_pkg.sv
// Shared definitions for the cache-line to memory-word bridge.
// Holds the bridge FSM state type and the line/word geometry constants.
package cache_bus_pkg;

  localparam int unsigned LINE_WIDTH = 128;
  localparam int unsigned WORD_WIDTH = 32;
  localparam int unsigned LINE_WORDS = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP,
    ST_RELEASE
  } bridge_state_e;

endpackage

// File: rtl/line_mem_bridge.sv
// line_mem_bridge: splits one cache-line request into four word beats on a
// request/grant/response memory bus, one beat outstanding at a time.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   addr_i, wdata_i, we_i   line request fields, valid with cs_i
//   cs_i                    request valid, held until rvalid_o
//   rdata_o                 assembled read line
//   rvalid_o                one-cycle completion pulse (reads and writes)
//   handshaked_o            one-cycle pulse in the accepting cycle
//   m_addr_o, m_wdata_o     beat address / write data
//   m_we_o, m_req_o         beat write enable / request (held until m_gnt_i)
//   m_gnt_i                 beat accepted
//   m_rdata_i, m_rvalid_i   beat response (read data or write acknowledge)
module line_mem_bridge #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned WORD_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [LINE_WIDTH-1:0] wdata_i,
  input  logic                  we_i,
  input  logic                  cs_i,
  output logic [LINE_WIDTH-1:0] rdata_o,
  output logic                  rvalid_o,
  output logic                  handshaked_o,
  output logic [ADDR_WIDTH-1:0] m_addr_o,
  output logic [WORD_WIDTH-1:0] m_wdata_o,
  output logic                  m_we_o,
  output logic                  m_req_o,
  input  logic                  m_gnt_i,
  input  logic [WORD_WIDTH-1:0] m_rdata_i,
  input  logic                  m_rvalid_i
);
  import cache_bus_pkg::*;

  localparam int unsigned BEATS  = LINE_WIDTH / WORD_WIDTH;
  localparam int unsigned CNT_W  = $clog2(BEATS);
  localparam int unsigned WOFS_W = $clog2(WORD_WIDTH / 8);
  localparam int unsigned LOFS_W = CNT_W + WOFS_W;
  localparam int unsigned BASE_W = ADDR_WIDTH - LOFS_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

  bridge_state_e                        state_q;
  logic [BASE_W-1:0]                    base_q;
  logic [BEATS-1:0][WORD_WIDTH-1:0]     wline_q;
  logic [BEATS-1:0][WORD_WIDTH-1:0]     rdata_q;
  logic                                 we_q;
  logic [CNT_W-1:0]                     cnt_q;
  logic [CNT_W-1:0]                     cnt_d;
  logic                                 rvalid_q;
  logic                                 m_req_q;
  logic                                 m_we_q;
  logic [ADDR_WIDTH-1:0]                m_addr_q;
  logic [WORD_WIDTH-1:0]                m_wdata_q;
  logic [BEATS-1:0][WORD_WIDTH-1:0]     wdata_words;
  logic                                 unused_addr_bits;

  assign wdata_words      = wdata_i;
  assign unused_addr_bits = ^addr_i[LOFS_W-1:0];
  assign cnt_d            = cnt_q + CNT_W'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      base_q    <= '0;
      wline_q   <= '0;
      rdata_q   <= '0;
      we_q      <= 1'b0;
      cnt_q     <= '0;
      rvalid_q  <= 1'b0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
    end else begin
      rvalid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cs_i) begin
            base_q    <= addr_i[ADDR_WIDTH-1:LOFS_W];
            wline_q   <= wdata_words;
            we_q      <= we_i;
            cnt_q     <= '0;
            // Beat 0 is presented straight from the inputs so m_req_o is
            // valid in the first REQ cycle.
            m_req_q   <= 1'b1;
            m_we_q    <= we_i;
            m_addr_q  <= {addr_i[ADDR_WIDTH-1:LOFS_W], {LOFS_W{1'b0}}};
            m_wdata_q <= wdata_words[0];
            state_q   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (m_gnt_i) begin
            m_req_q <= 1'b0;
            m_we_q  <= 1'b0;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (m_rvalid_i) begin
            if (!we_q) begin
              rdata_q[cnt_q] <= m_rdata_i;
            end
            cnt_q <= cnt_d;
            if (cnt_q == CNT_LAST) begin
              rvalid_q <= 1'b1;
              state_q  <= ST_RESP;
            end else begin
              m_req_q   <= 1'b1;
              m_we_q    <= we_q;
              m_addr_q  <= {base_q, cnt_d, {WOFS_W{1'b0}}};
              m_wdata_q <= wline_q[cnt_d];
              state_q   <= ST_REQ;
            end
          end
        end
        ST_RESP: begin
          state_q <= ST_RELEASE;
        end
        ST_RELEASE: begin
          if (!cs_i) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Acceptance is signalled in the IDLE cycle itself; gating with rst_i keeps
  // it low while reset is held even if cs_i is high.
  assign handshaked_o = (state_q == ST_IDLE) && cs_i && !rst_i;
  assign rdata_o      = rdata_q;
  assign rvalid_o     = rvalid_q;
  assign m_req_o      = m_req_q;
  assign m_we_o       = m_we_q;
  assign m_addr_o     = m_addr_q;
  assign m_wdata_o    = m_wdata_q;

endmodule

// File: doc/line_mem_bridge.md
LINE_MEM_BRIDGE -- requirements
Module: line_mem_bridge

Interface
REQ-001 Parameters (name, default, meaning) SHALL be as follows, one per line:
  ADDR_WIDTH  32   byte address width
  LINE_WIDTH  128  cache-line width, equal to the cache-side data width
  WORD_WIDTH  32   memory-side beat width; LINE_WIDTH/WORD_WIDTH = 4 beats
REQ-002 Ports (name, direction, width, meaning) SHALL be as follows, one per line:
  clk_i         in   1    single clock, all logic on rising edge
  rst_i         in   1    reset, asynchronous, active-high
  addr_i        in   32   line request address; bits [3:0] ignored
  wdata_i       in   128  line write data
  we_i          in   1    1 = line write, 0 = line read
  cs_i          in   1    request valid, held with stable fields until rvalid_o
  rdata_o       out  128  assembled read line
  rvalid_o      out  1    one-cycle completion pulse, for reads and writes
  handshaked_o  out  1    one-cycle pulse in the cycle the request is accepted
  m_addr_o      out  32   beat address
  m_wdata_o     out  32   beat write data
  m_we_o        out  1    beat write enable
  m_req_o       out  1    beat request, held until m_gnt_i
  m_gnt_i       in   1    beat accepted
  m_rdata_i     in   32   beat read data
  m_rvalid_i    in   1    beat response (read data or write acknowledge)

Function
REQ-003 The block SHALL implement an FSM with states IDLE, REQ, WAIT, RESP and RELEASE.
REQ-004 In IDLE with cs_i=1, the block SHALL capture addr_i[31:4], wdata_i and we_i, pulse handshaked_o, clear the 2-bit beat counter, and enter REQ.
REQ-005 In REQ, the block SHALL drive m_req_o=1, m_addr_o={line_base, cnt, 2'b00}, m_we_o=captured we, and m_wdata_o=captured wdata[32*cnt+31:32*cnt]; on m_gnt_i=1 it SHALL enter WAIT.
REQ-006 In WAIT, on m_rvalid_i=1 the block SHALL store m_rdata_i into rdata_o[32*cnt+31:32*cnt] (reads only) and increment cnt; it SHALL enter RESP if cnt==3, otherwise REQ.
REQ-007 RESP SHALL last exactly one cycle with rvalid_o=1; for reads, rdata_o SHALL hold the full line from this cycle until the next accepted read.
REQ-008 RELEASE SHALL wait for cs_i=0 and then enter IDLE, so that a held cs_i never causes a second acceptance.
REQ-009 The block SHALL allow only one beat outstanding; m_gnt_i outside REQ and m_rvalid_i outside WAIT SHALL be ignored.
REQ-010 Latency with a zero-wait slave (gnt in the REQ cycle, rvalid in the first WAIT cycle): acceptance at cycle T SHALL give rvalid_o at T+9.
REQ-011 Beats SHALL be issued in ascending address order 0x0, 0x4, 0x8, 0xC relative to the line base; the counter SHALL wrap 3->0 only on leaving WAIT.
REQ-012 Changes to cs_i or any request field after acceptance SHALL have no effect until RELEASE.
REQ-013 rvalid_o and handshaked_o SHALL never be asserted in the same cycle.

Reset
REQ-014 While rst_i=1, the block SHALL force the FSM to IDLE, cnt=0, and rdata_o, rvalid_o, handshaked_o, m_addr_o, m_wdata_o, m_we_o and m_req_o to 0, with no clock required.
REQ-015 A reset during any state SHALL abandon the transaction; no rvalid_o SHALL follow, and a late m_rvalid_i SHALL be ignored.

Structure
REQ-016 A shared package cache_bus_pkg SHALL hold typedef bridge_state_e and the constants LINE_WIDTH, WORD_WIDTH and LINE_WORDS=4.
REQ-017 The block SHALL be a single module with no sub-module; the line buffer and beat counter are inline registers.

Verification
REQ-018 Read with zero-wait slave: addr_i=0x0000_1234, memory words 0x11,0x22,0x33,0x44 -> beats at 0x1230, 0x1234, 0x1238, 0x123C; rdata_o=0x00000044_00000033_00000022_00000011; rvalid_o at T+9.
REQ-019 Write: wdata_i=0xDDDD_CCCC_BBBB_AAAA_... -> four beats with m_we_o=1 in ascending order, word 0 on 0x...0; one rvalid_o pulse.
REQ-020 Stalled slave: m_gnt_i delayed 3 cycles and m_rvalid_i delayed 2 cycles per beat -> m_req_o and m_addr_o stable while stalled; rvalid_o at T+1+4*(4+3)=T+29.
REQ-021 cs_i held high for 5 cycles after rvalid_o -> exactly one handshaked_o pulse; next acceptance only after cs_i has been low for at least one cycle.
REQ-022 rst_i asserted in WAIT after beat 2 -> all outputs 0 immediately; a spurious m_rvalid_i next cycle -> no rvalid_o.
